// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store controller and the data memory:
// funct3 values, the memory's store/load select codes and the FSM state type.
package lsu_pkg;

    // RISC-V funct3 values for loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Store select understood by the data memory
    localparam logic [2:0] S_NONE = 3'b000;
    localparam logic [2:0] S_SB   = 3'b001;
    localparam logic [2:0] S_SH   = 3'b010;
    localparam logic [2:0] S_SW   = 3'b100;

    // Load select understood by the data memory (it performs the extension)
    localparam logic [2:0] I_NONE = 3'b000;
    localparam logic [2:0] I_LB   = 3'b001;
    localparam logic [2:0] I_LH   = 3'b010;
    localparam logic [2:0] I_LW   = 3'b011;
    localparam logic [2:0] I_LBU  = 3'b100;
    localparam logic [2:0] I_LHU  = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Core-side request/response bundle of the load/store controller.
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high; the sender holds valid and its payload stable until then,
// and ready may depend on state but never on valid.
interface lsu_mem_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    // Controller side
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    // Core side
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/lsu_req_check.sv
// Combinational request decode: funct3 to memory select codes, plus the
// reject flag for illegal funct3, misalignment and out-of-range accesses.
module lsu_req_check
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_LIMIT  = 256,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    output logic        err,
    output logic [2:0]  s_ctrl,
    output logic [2:0]  i_ctrl
);

    logic        illegal;
    logic        misalign;
    logic        out_of_range;
    logic [1:0]  size_m1;
    logic [32:0] last_byte;

    // Decode funct3 into access size and the store/load select codes
    always_comb begin
        illegal = 1'b0;
        size_m1 = 2'd0;
        s_ctrl  = S_NONE;
        i_ctrl  = I_NONE;
        case (funct3)
            F3_B:  begin size_m1 = 2'd0; s_ctrl = S_SB; i_ctrl = I_LB;  end
            F3_H:  begin size_m1 = 2'd1; s_ctrl = S_SH; i_ctrl = I_LH;  end
            F3_W:  begin size_m1 = 2'd3; s_ctrl = S_SW; i_ctrl = I_LW;  end
            F3_BU: begin size_m1 = 2'd0; illegal = we;  i_ctrl = I_LBU; end
            F3_HU: begin size_m1 = 2'd1; illegal = we;  i_ctrl = I_LHU; end
            default: illegal = 1'b1;
        endcase
        if (we) i_ctrl = I_NONE;
        else    s_ctrl = S_NONE;
    end

    // Last byte is computed in 33 bits so addresses near 2^32 cannot wrap into range
    always_comb begin
        misalign     = CHECK_ALIGN && ((size_m1 == 2'd1 && addr[0]) ||
                                       (size_m1 == 2'd3 && addr[1:0] != 2'b00));
        last_byte    = {1'b0, addr} + {31'd0, size_m1};
        out_of_range = last_byte >= 33'(ADDR_LIMIT);
        err          = illegal | misalign | out_of_range;
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: accepts one request at a time, drives the data
// memory for exactly one ACCESS cycle and returns a registered response.
// Rejected requests skip ACCESS and never touch memory.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_LIMIT  = 256,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    lsu_mem_ctrl_if.slave bus,
    output logic          d_write_en,
    output logic [31:0]   d_addr,
    output logic [31:0]   d_write_data,
    output logic [2:0]    s_type_controls,
    output logic [2:0]    i_type_controls,
    input  logic [31:0]   d_read_data,
    output state_t        dbg_state
);

    state_t      state, state_next;
    logic        accept;
    logic        chk_err;
    logic [2:0]  chk_s, chk_i;
    logic        we_q;
    logic [2:0]  s_ctrl_q, i_ctrl_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic        err_q;

    lsu_req_check #(
        .ADDR_LIMIT  (ADDR_LIMIT),
        .CHECK_ALIGN (CHECK_ALIGN)
    ) u_check (
        .we     (bus.req_we),
        .funct3 (bus.req_funct3),
        .addr   (bus.req_addr),
        .err    (chk_err),
        .s_ctrl (chk_s),
        .i_ctrl (chk_i)
    );

    assign accept = bus.req_valid && bus.req_ready;

    // Next-state logic: rejected requests go straight to RESP
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = chk_err ? RESP : ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Request latch on acceptance; load data captured on the edge leaving ACCESS
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q     <= 1'b0;
            s_ctrl_q <= S_NONE;
            i_ctrl_q <= I_NONE;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else if (accept) begin
            we_q     <= bus.req_we;
            s_ctrl_q <= chk_s;
            i_ctrl_q <= chk_i;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            rdata_q  <= 32'd0;
            err_q    <= chk_err;
        end else if (state == ACCESS) begin
            rdata_q  <= we_q ? 32'd0 : d_read_data;
        end
    end

    // Memory strobes are live only in ACCESS, so an async reset drops them at once
    assign d_write_en      = (state == ACCESS) && we_q;
    assign s_type_controls = (state == ACCESS && we_q)  ? s_ctrl_q : S_NONE;
    assign i_type_controls = (state == ACCESS && !we_q) ? i_ctrl_q : I_NONE;
    assign d_addr          = addr_q;
    assign d_write_data    = wdata_q;

    assign bus.req_ready = (state == IDLE) && !reset;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl. Two instances share one byte memory model:
// dut_a with alignment checking, dut_b without; use_b selects which one the
// core-side drivers talk to.
module tb_lsu_mem_ctrl;
    import lsu_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- core-side drive ----------------
    logic        use_b = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_ready = 1'b0;

    lsu_mem_ctrl_if bus_a ();
    lsu_mem_ctrl_if bus_b ();

    assign bus_a.req_valid  = req_valid & ~use_b;
    assign bus_b.req_valid  = req_valid & use_b;
    assign bus_a.rsp_ready  = rsp_ready & ~use_b;
    assign bus_b.rsp_ready  = rsp_ready & use_b;
    assign bus_a.req_we     = req_we;
    assign bus_b.req_we     = req_we;
    assign bus_a.req_funct3 = req_funct3;
    assign bus_b.req_funct3 = req_funct3;
    assign bus_a.req_addr   = req_addr;
    assign bus_b.req_addr   = req_addr;
    assign bus_a.req_wdata  = req_wdata;
    assign bus_b.req_wdata  = req_wdata;

    wire        req_ready_m = use_b ? bus_b.req_ready : bus_a.req_ready;
    wire        rsp_valid_m = use_b ? bus_b.rsp_valid : bus_a.rsp_valid;
    wire [31:0] rsp_rdata_m = use_b ? bus_b.rsp_rdata : bus_a.rsp_rdata;
    wire        rsp_err_m   = use_b ? bus_b.rsp_err   : bus_a.rsp_err;

    // ---------------- DUTs ----------------
    logic        a_we, b_we;
    logic [31:0] a_addr, b_addr, a_wd, b_wd;
    logic [2:0]  a_s, b_s, a_i, b_i;
    logic [31:0] rd_data;
    state_t      state_a, state_b;

    lsu_mem_ctrl #(.ADDR_LIMIT(256), .CHECK_ALIGN(1'b1)) dut_a (
        .clk (clk), .reset (reset), .bus (bus_a),
        .d_write_en (a_we), .d_addr (a_addr), .d_write_data (a_wd),
        .s_type_controls (a_s), .i_type_controls (a_i),
        .d_read_data (rd_data), .dbg_state (state_a)
    );

    lsu_mem_ctrl #(.ADDR_LIMIT(256), .CHECK_ALIGN(1'b0)) dut_b (
        .clk (clk), .reset (reset), .bus (bus_b),
        .d_write_en (b_we), .d_addr (b_addr), .d_write_data (b_wd),
        .s_type_controls (b_s), .i_type_controls (b_i),
        .d_read_data (rd_data), .dbg_state (state_b)
    );

    // ---------------- data memory model ----------------
    wire        m_we = use_b ? b_we : a_we;
    wire [7:0]  m_a  = use_b ? b_addr[7:0] : a_addr[7:0];
    wire [31:0] m_wd = use_b ? b_wd : a_wd;
    wire [2:0]  m_s  = use_b ? b_s : a_s;
    wire [2:0]  m_i  = use_b ? b_i : a_i;
    logic [7:0] mem [256];
    int         wen_count = 0;

    always @(posedge clk) begin
        if (m_we) begin
            case (m_s)
                S_SB: mem[m_a] = m_wd[7:0];
                S_SH: begin mem[m_a] = m_wd[7:0]; mem[m_a + 8'd1] = m_wd[15:8]; end
                S_SW: begin
                    mem[m_a] = m_wd[7:0];           mem[m_a + 8'd1] = m_wd[15:8];
                    mem[m_a + 8'd2] = m_wd[23:16];  mem[m_a + 8'd3] = m_wd[31:24];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_data = 32'd0;
        case (m_i)
            I_LB:  rd_data = {{24{mem[m_a][7]}}, mem[m_a]};
            I_LH:  rd_data = {{16{mem[m_a + 8'd1][7]}}, mem[m_a + 8'd1], mem[m_a]};
            I_LW:  rd_data = {mem[m_a + 8'd3], mem[m_a + 8'd2], mem[m_a + 8'd1], mem[m_a]};
            I_LBU: rd_data = {24'd0, mem[m_a]};
            I_LHU: rd_data = {16'd0, mem[m_a + 8'd1], mem[m_a]};
            default: rd_data = 32'd0;
        endcase
    end

    always @(negedge clk) if (m_we) wen_count++;

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd);
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        for (int i = 0; i < 20 && !req_ready_m; i++) @(negedge clk);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid_m && lat < 20);
    endtask

    task automatic finish_rsp();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic err,
                        output int lat, output int wen);
        int wen_start;
        wen_start = wen_count;
        send(we, f3, addr, wd);
        wait_rsp(lat);
        rd  = rsp_rdata_m;
        err = rsp_err_m;
        finish_rsp();
        wen = wen_count - wen_start;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] rd, held;
        logic        err;
        int          lat, wen, wen_before;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        // Reset state
        #12;
        check("rst_req_ready", 32'(bus_a.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
        check("rst_rsp_err",   32'(bus_a.rsp_err),   32'd0);
        check("rst_rsp_rdata", bus_a.rsp_rdata,      32'd0);
        check("rst_d_we",      32'(a_we),            32'd0);
        check("rst_d_addr",    a_addr,               32'd0);
        check("rst_d_wdata",   a_wd,                 32'd0);
        check("rst_ctrls",     {26'd0, a_s, a_i},    32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1 check("post_rst_ready", 32'(bus_a.req_ready), 32'd1);

        // SW 0x10 then LW 0x10
        xact(1'b1, F3_W, 32'h10, 32'hDEADBEEF, rd, err, lat, wen);
        check("sw10_err", 32'(err), 32'd0);
        check("sw10_rdata", rd, 32'd0);
        check("sw10_lat", 32'(lat), 32'd2);
        check("sw10_we_cycles", 32'(wen), 32'd1);
        xact(1'b0, F3_W, 32'h10, 32'h0, rd, err, lat, wen);
        check("lw10_rdata", rd, 32'hDEADBEEF);
        check("lw10_err", 32'(err), 32'd0);
        check("lw10_lat", 32'(lat), 32'd2);
        check("lw10_we_cycles", 32'(wen), 32'd0);
        check("d_addr_held", a_addr, 32'h10);
        check("ctrls_idle", {26'd0, a_s, a_i}, 32'd0);

        // Byte store then signed / unsigned byte loads
        xact(1'b1, F3_B, 32'h21, 32'h000000F0, rd, err, lat, wen);
        check("sb21_err", 32'(err), 32'd0);
        xact(1'b0, F3_B, 32'h21, 32'h0, rd, err, lat, wen);
        check("lb21_rdata", rd, 32'hFFFFFFF0);
        xact(1'b0, F3_BU, 32'h21, 32'h0, rd, err, lat, wen);
        check("lbu21_rdata", rd, 32'h000000F0);

        // Misaligned with alignment checking
        xact(1'b0, F3_H, 32'h11, 32'h0, rd, err, lat, wen);
        check("lh11_err", 32'(err), 32'd1);
        check("lh11_rdata", rd, 32'd0);
        check("lh11_lat", 32'(lat), 32'd1);
        check("lh11_we_cycles", 32'(wen), 32'd0);
        xact(1'b0, F3_W, 32'h12, 32'h0, rd, err, lat, wen);
        check("lw12_err", 32'(err), 32'd1);
        check("lw12_rdata", rd, 32'd0);
        check("lw12_lat", 32'(lat), 32'd1);

        // Same halfword load without alignment checking: bytes BE, AD
        use_b = 1'b1;
        xact(1'b0, F3_H, 32'h11, 32'h0, rd, err, lat, wen);
        check("noalign_lh11_err", 32'(err), 32'd0);
        check("noalign_lh11_rdata", rd, 32'hFFFFADBE);
        check("noalign_lh11_lat", 32'(lat), 32'd2);
        use_b = 1'b0;

        // Range limits and illegal store funct3
        xact(1'b0, F3_W, 32'hFD, 32'h0, rd, err, lat, wen);
        check("lwFD_err", 32'(err), 32'd1);
        xact(1'b0, F3_W, 32'hFC, 32'h0, rd, err, lat, wen);
        check("lwFC_err", 32'(err), 32'd0);
        check("lwFC_rdata", rd, 32'd0);
        xact(1'b0, F3_B, 32'hFFFFFFFF, 32'h0, rd, err, lat, wen);
        check("lb_top_err", 32'(err), 32'd1);
        xact(1'b1, 3'b011, 32'h10, 32'h11111111, rd, err, lat, wen);
        check("s011_err", 32'(err), 32'd1);
        check("s011_we_cycles", 32'(wen), 32'd0);
        xact(1'b1, F3_BU, 32'h10, 32'h22222222, rd, err, lat, wen);
        check("s100_err", 32'(err), 32'd1);
        xact(1'b0, F3_W, 32'h10, 32'h0, rd, err, lat, wen);
        check("lw10_unchanged", rd, 32'hDEADBEEF);

        // Response back-pressure with a second request waiting
        send(1'b0, F3_W, 32'h10, 32'h0);
        wait_rsp(lat);
        held = rsp_rdata_m;
        check("bp_held", held, 32'hDEADBEEF);
        req_we = 1'b0; req_funct3 = F3_BU; req_addr = 32'h21; req_wdata = 32'h0;
        req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid_m), 32'd1);
            check("bp_rdata_stable", rsp_rdata_m, 32'hDEADBEEF);
            check("bp_req_ready", 32'(req_ready_m), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check("bp_back_idle", 32'(state_a), 32'(IDLE));
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("bp_second_accepted", 32'(state_a), 32'(ACCESS));
        wait_rsp(lat);
        check("bp_second_rdata", rsp_rdata_m, 32'h000000F0);
        finish_rsp();

        // Reset during the ACCESS cycle of a store
        xact(1'b1, F3_W, 32'h40, 32'hCAFEF00D, rd, err, lat, wen);
        wen_before = wen_count;
        send(1'b1, F3_W, 32'h40, 32'h12345678);
        check("rst_mid_in_access", 32'(a_we), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_we_drop", 32'(a_we), 32'd0);
        check("rst_mid_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_no_write", 32'(wen_count - wen_before), 32'd0);
        xact(1'b0, F3_W, 32'h40, 32'h0, rd, err, lat, wen);
        check("rst_mid_prior_data", rd, 32'hCAFEF00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
